// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the packet stream scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package pkt_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LAUNCH,
    S_WAIT_TX,
    S_GAP,
    S_DONE
  } sched_state_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] pkt_len;
    logic        ipv6;
    logic [15:0] pkt_count;
  } flow_desc_t;

  localparam int          MIN_GAP_DEF     = 2;
  localparam logic [95:0] IPV6_PREFIX_DEF =
    96'hFD00_0000_0000_0000_0000_0000;

  // Gap counter load value: the final gap cycle is counted separately.
  function automatic logic [15:0] gap_load(
    input logic [15:0] req,
    input logic [15:0] floor
  );
    return ((req < floor) ? floor : req) - 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant.
// The parent registers grant_idx.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    j           = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last_grant) + k;
      if (j >= N) j = j - N;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pkt_stream_scheduler.sv
// Round-robin packet scheduler driving a single-packet UDP generator
// across a set of programmed flow descriptors.
module pkt_stream_scheduler
  import pkt_sched_pkg::*;
#(
  parameter int          NUM_STREAMS = 4,
  parameter int          TX_TIMEOUT  = 1024,
  parameter int          MIN_GAP     = MIN_GAP_DEF,
  parameter logic [95:0] IPV6_PREFIX = IPV6_PREFIX_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(NUM_STREAMS)-1:0] cfg_wr_idx,
  input  logic [31:0]                    cfg_src_ip,
  input  logic [31:0]                    cfg_dst_ip,
  input  logic [15:0]                    cfg_src_port,
  input  logic [15:0]                    cfg_dst_port,
  input  logic [15:0]                    cfg_pkt_len,
  input  logic                           cfg_ipv6,
  input  logic [15:0]                    cfg_pkt_count,
  input  logic [15:0]                    gap_cycles,
  output logic                           gen_enable,
  output logic [31:0]                    gen_src_ip,
  output logic [31:0]                    gen_dst_ip,
  output logic [15:0]                    gen_src_port,
  output logic [15:0]                    gen_dst_port,
  output logic [15:0]                    gen_packet_length,
  output logic                           gen_ipv6_mode,
  output logic [127:0]                   gen_src_ipv6,
  output logic [127:0]                   gen_dst_ipv6,
  input  logic                           mon_tvalid,
  input  logic                           mon_tready,
  input  logic                           mon_tlast,
  output logic                           busy,
  output logic                           done,
  output logic                           tx_err,
  output logic [$clog2(NUM_STREAMS)-1:0] cur_stream,
  output logic [31:0]                    total_sent
);

  localparam int IW = $clog2(NUM_STREAMS);
  localparam int TW = $clog2(TX_TIMEOUT + 1);

  sched_state_t state, state_next;

  flow_desc_t  desc      [NUM_STREAMS];
  logic [15:0] remaining [NUM_STREAMS];

  logic [NUM_STREAMS-1:0] req;
  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          arb_idx;
  logic                   arb_valid;
  logic [TW-1:0]          tcnt;
  logic [15:0]            gap_cnt;

  logic ld_run, grant, launch;
  logic tx_ok, tx_to, gap_dec, done_set;
  logic wr_ok, pkt_end;

  assign wr_ok   = cfg_wr_en && (state == S_IDLE);
  assign pkt_end = mon_tvalid && mon_tready && mon_tlast;
  assign busy    = (state != S_IDLE);

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      req[i] = |remaining[i];
    end
  end

  rr_arbiter #(
    .N (NUM_STREAMS)
  ) u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_run     = 1'b0;
    grant      = 1'b0;
    launch     = 1'b0;
    tx_ok      = 1'b0;
    tx_to      = 1'b0;
    gap_dec    = 1'b0;
    done_set   = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ld_run     = 1'b1;
            state_next = S_ARB;
          end
        end
        S_ARB: begin
          grant      = arb_valid;
          state_next = arb_valid ? S_LAUNCH : S_DONE;
        end
        S_LAUNCH: begin
          launch     = 1'b1;
          state_next = S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (pkt_end) begin
            tx_ok      = 1'b1;
            state_next = S_GAP;
          end else if (tcnt == TW'(TX_TIMEOUT - 1)) begin
            tx_to      = 1'b1;
            state_next = S_GAP;
          end
        end
        S_GAP: begin
          // Last gap cycle also arbitrates, so enable-low time equals the gap.
          if (gap_cnt <= 16'd1) begin
            grant      = arb_valid;
            state_next = arb_valid ? S_LAUNCH : S_DONE;
          end else begin
            gap_dec = 1'b1;
          end
        end
        S_DONE: begin
          done_set   = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        desc[i]      <= '0;
        remaining[i] <= '0;
      end
      last_grant        <= IW'(NUM_STREAMS - 1);
      cur_stream        <= '0;
      gen_enable        <= 1'b0;
      gen_src_ip        <= '0;
      gen_dst_ip        <= '0;
      gen_src_port      <= '0;
      gen_dst_port      <= '0;
      gen_packet_length <= '0;
      gen_ipv6_mode     <= 1'b0;
      gen_src_ipv6      <= '0;
      gen_dst_ipv6      <= '0;
      done              <= 1'b0;
      tx_err            <= 1'b0;
      total_sent        <= '0;
      tcnt              <= '0;
      gap_cnt           <= '0;
    end else begin
      done <= done_set;
      if (wr_ok && (int'(cfg_wr_idx) < NUM_STREAMS)) begin
        desc[cfg_wr_idx] <= '{
          src_ip:    cfg_src_ip,
          dst_ip:    cfg_dst_ip,
          src_port:  cfg_src_port,
          dst_port:  cfg_dst_port,
          pkt_len:   cfg_pkt_len,
          ipv6:      cfg_ipv6,
          pkt_count: cfg_pkt_count
        };
      end
      if (abort) begin
        gen_enable <= 1'b0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
          remaining[i] <= '0;
        end
      end else begin
        if (ld_run) begin
          // A same-cycle write lands first, so use its count directly.
          for (int i = 0; i < NUM_STREAMS; i++) begin
            if (wr_ok && (int'(cfg_wr_idx) == i))
              remaining[i] <= cfg_pkt_count;
            else
              remaining[i] <= desc[i].pkt_count;
          end
          total_sent <= '0;
          tx_err     <= 1'b0;
        end
        if (grant) begin
          cur_stream <= arb_idx;
          last_grant <= arb_idx;
        end
        if (launch) begin
          gen_src_ip        <= desc[cur_stream].src_ip;
          gen_dst_ip        <= desc[cur_stream].dst_ip;
          gen_src_port      <= desc[cur_stream].src_port;
          gen_dst_port      <= desc[cur_stream].dst_port;
          gen_packet_length <= desc[cur_stream].pkt_len;
          gen_ipv6_mode     <= desc[cur_stream].ipv6;
          gen_src_ipv6      <= {IPV6_PREFIX, desc[cur_stream].src_ip};
          gen_dst_ipv6      <= {IPV6_PREFIX, desc[cur_stream].dst_ip};
          gen_enable        <= 1'b1;
          tcnt              <= '0;
        end
        if (state == S_WAIT_TX) begin
          tcnt <= tcnt + TW'(1);
        end
        if (tx_ok || tx_to) begin
          gen_enable <= 1'b0;
          gap_cnt    <= gap_load(gap_cycles, 16'(MIN_GAP));
          if (remaining[cur_stream] != 16'd0)
            remaining[cur_stream] <= remaining[cur_stream] - 16'd1;
        end
        if (tx_ok) total_sent <= total_sent + 32'd1;
        if (tx_to) tx_err     <= 1'b1;
        if (gap_dec) gap_cnt  <= gap_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_stream_scheduler.sv
// Directed bench for pkt_stream_scheduler with a launch/gap scoreboard
// and a small generator model answering on the monitor tap.
module tb_pkt_stream_scheduler;

  localparam int NS = 4;
  localparam int IW = $clog2(NS);

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic          cfg_wr_en;
  logic [IW-1:0] cfg_wr_idx;
  logic [31:0]   cfg_src_ip, cfg_dst_ip;
  logic [15:0]   cfg_src_port, cfg_dst_port, cfg_pkt_len;
  logic          cfg_ipv6;
  logic [15:0]   cfg_pkt_count, gap_cycles;
  logic          gen_enable;
  logic [31:0]   gen_src_ip, gen_dst_ip;
  logic [15:0]   gen_src_port, gen_dst_port, gen_packet_length;
  logic          gen_ipv6_mode;
  logic [127:0]  gen_src_ipv6, gen_dst_ipv6;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic          mon_tlast  = 1'b0;
  logic          busy, done, tx_err;
  logic [IW-1:0] cur_stream;
  logic [31:0]   total_sent;

  pkt_stream_scheduler #(
    .NUM_STREAMS (NS),
    .TX_TIMEOUT  (16),
    .MIN_GAP     (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .cfg_wr_en         (cfg_wr_en),
    .cfg_wr_idx        (cfg_wr_idx),
    .cfg_src_ip        (cfg_src_ip),
    .cfg_dst_ip        (cfg_dst_ip),
    .cfg_src_port      (cfg_src_port),
    .cfg_dst_port      (cfg_dst_port),
    .cfg_pkt_len       (cfg_pkt_len),
    .cfg_ipv6          (cfg_ipv6),
    .cfg_pkt_count     (cfg_pkt_count),
    .gap_cycles        (gap_cycles),
    .gen_enable        (gen_enable),
    .gen_src_ip        (gen_src_ip),
    .gen_dst_ip        (gen_dst_ip),
    .gen_src_port      (gen_src_port),
    .gen_dst_port      (gen_dst_port),
    .gen_packet_length (gen_packet_length),
    .gen_ipv6_mode     (gen_ipv6_mode),
    .gen_src_ipv6      (gen_src_ipv6),
    .gen_dst_ipv6      (gen_dst_ipv6),
    .mon_tvalid        (mon_tvalid),
    .mon_tready        (mon_tready),
    .mon_tlast         (mon_tlast),
    .busy              (busy),
    .done              (done),
    .tx_err            (tx_err),
    .cur_stream        (cur_stream),
    .total_sent        (total_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stream;
    logic [31:0] src_ip;
    logic        ipv6;
  } exp_t;

  exp_t exp_q [$];
  int   gap_q [$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int rises    = 0;
  logic rdy = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Generator model: three beats per packet, tlast on the third.
  int   beat = 0;
  logic sent = 1'b0;
  always @(negedge clk) begin
    if (!gen_enable) begin
      beat = 0;
      sent = 1'b0;
    end else if (mon_tvalid && mon_tready) begin
      if (mon_tlast) sent = 1'b1;
      else beat = beat + 1;
    end
    mon_tready = rdy;
    mon_tvalid = gen_enable && !sent;
    mon_tlast  = gen_enable && !sent && (beat == 2);
  end

  // Scoreboard monitor: launches and enable-low gap lengths.
  logic prev_en = 1'b0;
  logic had_pkt = 1'b0;
  int   low_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (done) done_cnt++;
    if (gen_enable && !prev_en) begin
      rises++;
      chk("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cur_stream", 128'(cur_stream), 128'(e.stream));
        chk("gen_src_ip", 128'(gen_src_ip), 128'(e.src_ip));
        chk("gen_ipv6_mode", 128'(gen_ipv6_mode), 128'(e.ipv6));
        chk("gen_src_ipv6", gen_src_ipv6,
            {96'hFD00_0000_0000_0000_0000_0000, e.src_ip});
        chk("gen_pkt_len", 128'(gen_packet_length),
            128'(16'd64 + 16'(e.stream)));
      end
      if (had_pkt) begin
        chk("gap_nonempty", 128'(gap_q.size() != 0), 128'd1);
        if (gap_q.size() != 0) begin
          g = gap_q.pop_front();
          chk("gap_len", 128'(low_cnt), 128'(g));
        end
      end
      had_pkt = 1'b1;
      low_cnt = 0;
    end else if (!busy) begin
      had_pkt = 1'b0;
      low_cnt = 0;
    end else if (!gen_enable && had_pkt) begin
      low_cnt++;
    end
    prev_en = gen_enable;
  end

  function automatic logic [31:0] src_of(input int idx);
    return 32'h0A00_0000 + 32'(idx) + 32'h100;
  endfunction

  task automatic wr_desc(input int idx, input logic [31:0] sip,
                         input int cnt, input logic v6);
    cfg_wr_en     = 1'b1;
    cfg_wr_idx    = IW'(idx);
    cfg_src_ip    = sip;
    cfg_dst_ip    = 32'hC0A8_0000 | 32'(idx);
    cfg_src_port  = 16'(1000 + idx);
    cfg_dst_port  = 16'(2000 + idx);
    cfg_pkt_len   = 16'(64 + idx);
    cfg_ipv6      = v6;
    cfg_pkt_count = 16'(cnt);
    @(posedge clk);
    #1 cfg_wr_en = 1'b0;
  endtask

  task automatic push(input int s, input logic [31:0] sip,
                      input logic v6);
    exp_t e;
    e.stream = s;
    e.src_ip = sip;
    e.ipv6   = v6;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 2000) begin
      @(posedge clk);
      #1 c++;
    end
    chk(tag, 128'(done), 128'd1);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
  endtask

  task automatic wait_en(input string tag);
    int c;
    c = 0;
    while (!gen_enable && c < 200) begin
      @(posedge clk);
      #1 c++;
    end
    chk(tag, 128'(gen_enable), 128'd1);
  endtask

  initial begin
    int d0, r0, c;
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_wr_en = 1'b0;
    cfg_wr_idx = '0; cfg_src_ip = '0; cfg_dst_ip = '0;
    cfg_src_port = '0; cfg_dst_port = '0; cfg_pkt_len = '0;
    cfg_ipv6 = 1'b0; cfg_pkt_count = '0; gap_cycles = 16'd4;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_gen_enable", 128'(gen_enable), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_tx_err", 128'(tx_err), 128'd0);
    chk("rst_total", 128'(total_sent), 128'd0);
    chk("rst_cur", 128'(cur_stream), 128'd0);

    // Flows 0/1 counts 3/1, gap 4: grants 0,1,0,0.
    wr_desc(0, src_of(0), 3, 1'b0);
    wr_desc(1, src_of(1), 1, 1'b0);
    wr_desc(2, src_of(2), 0, 1'b0);
    wr_desc(3, src_of(3), 0, 1'b0);
    push(0, src_of(0), 1'b0); push(1, src_of(1), 1'b0);
    push(0, src_of(0), 1'b0); push(0, src_of(0), 1'b0);
    gap_q.push_back(4); gap_q.push_back(4); gap_q.push_back(4);
    d0 = done_cnt;
    pulse_start();
    chk("lat_busy", 128'(busy), 128'd1);
    @(posedge clk); #1;
    chk("lat_k1_en", 128'(gen_enable), 128'd0);
    @(posedge clk); #1;
    chk("lat_k2_en", 128'(gen_enable), 128'd1);
    wait_done("t1_done");
    chk("t1_total", 128'(total_sent), 128'd4);
    repeat (3) @(posedge clk);
    #1 chk("t1_done_once", 128'(done_cnt - d0), 128'd1);
    chk("t1_done_low", 128'(done), 128'd0);

    // gap_cycles 0 -> minimum gap of 2.
    wr_desc(0, src_of(0), 0, 1'b0);
    wr_desc(1, src_of(1), 0, 1'b0);
    wr_desc(3, src_of(3), 2, 1'b0);
    gap_cycles = 16'd0;
    push(3, src_of(3), 1'b0); push(3, src_of(3), 1'b0);
    gap_q.push_back(2);
    pulse_start();
    wait_done("t2_done");
    chk("t2_total", 128'(total_sent), 128'd2);

    // gap_cycles 7 with flows 1 and 3.
    wr_desc(1, src_of(1), 1, 1'b0);
    wr_desc(3, src_of(3), 1, 1'b0);
    gap_cycles = 16'd7;
    push(1, src_of(1), 1'b0); push(3, src_of(3), 1'b0);
    gap_q.push_back(7);
    pulse_start();
    wait_done("t3_done");

    // IPv6 flow 2 only.
    wr_desc(1, src_of(1), 0, 1'b0);
    wr_desc(3, src_of(3), 0, 1'b0);
    wr_desc(2, 32'h0A00_0001, 1, 1'b1);
    gap_cycles = 16'd2;
    push(2, 32'h0A00_0001, 1'b1);
    pulse_start();
    wait_en("t4_en");
    chk("t4_v6_mode", 128'(gen_ipv6_mode), 128'd1);
    chk("t4_src_v6", gen_src_ipv6,
        128'hFD00_0000_0000_0000_0000_0000_0A00_0001);
    wait_done("t4_done");

    // Timeout: tready held low.
    rdy = 1'b0;
    d0 = done_cnt;
    push(2, 32'h0A00_0001, 1'b1);
    pulse_start();
    wait_en("t5_en");
    c = 0;
    while (!tx_err && c < 60) begin
      @(posedge clk);
      #1 c++;
    end
    chk("t5_timeout_cycles", 128'(c), 128'd16);
    chk("t5_en_drop", 128'(gen_enable), 128'd0);
    wait_done("t5_done");
    chk("t5_total", 128'(total_sent), 128'd0);
    chk("t5_tx_err", 128'(tx_err), 128'd1);
    rdy = 1'b1;

    // All counts zero: done at edge k+2, no enable.
    wr_desc(2, 32'h0A00_0001, 0, 1'b1);
    r0 = rises;
    pulse_start();
    chk("t6_k_done", 128'(done), 128'd0);
    chk("t6_tx_err_clr", 128'(tx_err), 128'd0);
    @(posedge clk); #1;
    chk("t6_k1_done", 128'(done), 128'd0);
    @(posedge clk); #1;
    chk("t6_k2_done", 128'(done), 128'd1);
    chk("t6_k2_busy", 128'(busy), 128'd0);
    chk("t6_no_enable", 128'(rises - r0), 128'd0);

    // Abort during WAIT_TX, then rerun full counts.
    rdy = 1'b0;
    wr_desc(0, src_of(0), 5, 1'b0);
    push(0, src_of(0), 1'b0);
    d0 = done_cnt;
    pulse_start();
    wait_en("t7_en");
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("t7_abort_en", 128'(gen_enable), 128'd0);
    chk("t7_abort_busy", 128'(busy), 128'd0);
    repeat (6) @(posedge clk);
    #1 chk("t7_no_done", 128'(done_cnt - d0), 128'd0);
    chk("t7_total_kept", 128'(total_sent), 128'd0);
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) push(0, src_of(0), 1'b0);
    for (int i = 0; i < 4; i++) gap_q.push_back(2);
    pulse_start();
    wait_done("t7_rerun_done");
    chk("t7_total", 128'(total_sent), 128'd5);

    repeat (4) @(posedge clk);
    #1 chk("sb_drained", 128'(exp_q.size() + gap_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pkt_stream_scheduler.md
Name: pkt_stream_scheduler

Overview:
- Sequences the single-packet Ethernet/IPv4/IPv6 UDP generator across up to NUM_STREAMS programmed flows.
- Each flow has its own header fields and packet count. Flows are granted round-robin, one packet at a time.
- For each grant the block drives the generator config and enable, watches the generator's AXI-Stream output for end-of-packet, then applies an inter-packet gap.
- Sits between the filter_rx_pipeline testbench control and the generator.

Parameters:
- NUM_STREAMS, 4, number of flow descriptors (2..16).
- TX_TIMEOUT, 1024, max cycles to wait for packet acceptance before flagging an error.
- MIN_GAP, 2, minimum enable-low cycles between packets; lets the generator return to IDLE.
- IPV6_PREFIX, 96'hFD00_0000_0000_0000_0000_0000, upper 96 bits of generated IPv6 addresses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; loads working counts and begins scheduling
- abort  in  1  stop immediately and return to IDLE
- cfg_wr_en  in  1  descriptor write strobe; ignored while busy
- cfg_wr_idx  in  $clog2(NUM_STREAMS)  descriptor index
- cfg_src_ip / cfg_dst_ip  in  32 each  IPv4 addresses; also the low 32 bits of the IPv6 addresses
- cfg_src_port / cfg_dst_port  in  16 each  UDP ports
- cfg_pkt_len  in  16  packet_length value
- cfg_ipv6  in  1  flow uses IPv6
- cfg_pkt_count  in  16  packets to send per run (0 = flow disabled)
- gap_cycles  in  16  requested inter-packet gap
- gen_enable  out  1  generator enable
- gen_src_ip, gen_dst_ip  out  32  to generator
- gen_src_port, gen_dst_port, gen_packet_length  out  16  to generator
- gen_ipv6_mode  out  1  to generator
- gen_src_ipv6, gen_dst_ipv6  out  128  {IPV6_PREFIX, cfg ip}
- mon_tvalid, mon_tready, mon_tlast  in  1 each  tap of generator output handshake
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when all flows are exhausted
- tx_err  out  1  sticky timeout flag; cleared by start or reset
- cur_stream  out  $clog2(NUM_STREAMS)  flow currently granted
- total_sent  out  32  packets completed since start; wraps at 2^32

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = NUM_STREAMS-1. Descriptors reset: count 0, all fields 0.
- Descriptor storage is persistent across runs. start copies every cfg_pkt_count into remaining[i], clears total_sent and tx_err.
- States: IDLE, ARB, LAUNCH, WAIT_TX, GAP, DONE.
- IDLE:
  - cfg writes are accepted.
  - start -> ARB.
  - start and cfg_wr_en in the same cycle: the write lands first; start uses the new count.
- ARB (1 cycle):
  - Search from last_grant+1, wrapping, for the first i with remaining[i] != 0.
  - Found: cur_stream = i, last_grant = i -> LAUNCH.
  - None found -> DONE.
- LAUNCH: gen_* fields registered from descriptor cur_stream; gen_enable = 1 -> WAIT_TX. gen_* stay stable until the next LAUNCH.
- Latency: start sampled at edge k -> gen_enable high after edge k+2.
- WAIT_TX:
  - gen_enable held 1; timeout counter increments each cycle.
  - mon_tvalid & mon_tready & mon_tlast completes the packet: remaining[cur_stream] -= 1, total_sent += 1, gen_enable <= 0, load gap counter with max(gap_cycles, MIN_GAP) -> GAP.
  - Counter reaches TX_TIMEOUT: tx_err <= 1, remaining[cur_stream] -= 1 (no hang), total_sent unchanged, gen_enable <= 0 -> GAP.
- GAP: gen_enable = 0; decrement the counter; at 1 -> ARB. gen_enable low for exactly max(gap_cycles, MIN_GAP) cycles between packets.
- DONE: done = 1 for one cycle -> IDLE.
- remaining[] never underflows; decrement only when non-zero.
- abort (any state, takes priority over all other events): gen_enable <= 0, state IDLE next cycle, remaining cleared to 0. done not asserted; tx_err and total_sent retained.
- start while busy: ignored. cfg_wr_en while busy: ignored.
- Reset mid-packet: gen_enable drops at the next edge; the generator finishes or idles on its own.

Decomposition:
- Shared package pkt_sched_pkg holds:
  - state enum sched_state_t;
  - struct flow_desc_t {src_ip, dst_ip, src_port, dst_port, pkt_len, ipv6, pkt_count};
  - MIN_GAP default and the IPv6 prefix constant.
- One natural sub-module: rr_arbiter. Inputs: NUM_STREAMS request vector, last_grant. Outputs: grant_idx, grant_valid. Purely combinational, registered by the parent.

Test Plan:
- Flows 0/1 with counts 3/1, gap 4, generator tready=1 -> grants in order 0,1,0,0. total_sent = 4. done pulses once, 1 cycle after the last GAP. busy falls the same cycle.
- gap_cycles = 0 -> gen_enable low exactly 2 cycles between packets. gap_cycles = 7 -> exactly 7 cycles.
- Flow 2 only, IPv6, src_ip = 32'h0A000001 -> gen_src_ipv6 = 128'hFD00_0000_0000_0000_0000_0000_0A00_0001 and gen_ipv6_mode = 1 while gen_enable is high.
- Generator tready held 0, TX_TIMEOUT = 16, count 1 -> tx_err set 16 cycles after gen_enable rises. gen_enable drops. total_sent = 0. done pulses.
- All counts 0, start -> ARB then DONE: done pulses at edge k+2. gen_enable never asserted.
- abort asserted in WAIT_TX with remaining 5 -> gen_enable 0 and state IDLE next cycle, no done. A following start reruns the full programmed counts.
